alu_muldiv_seq: RTL

- Iterative multi-cycle multiply/divide unit. Produces the multiplication and division results that the combinational ALU selects for control codes 4'b0101 (mult) and 4'b0100 (div).
- Takes the same A/B/control operands as the ALU and returns a registered result with a start/done handshake.
- Sits beside the ALU in the execution stage. The stage controller stalls while busy is high.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_muldiv_seq_if.sv | 27 ++
 rtl/alu_muldiv_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Definitions shared by the combinational ALU and the sequential multiply/divide unit:
// operation codes and the multiply/divide controller states.
package alu_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0111;
  localparam logic [3:0] ALU_S   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Operand/result bundle between the execution-stage controller (master)
// and the sequential multiply/divide unit (slave).
interface alu_muldiv_seq_if #(
  parameter int n = 32
);

  logic         start;
  logic [3:0]   control;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         busy;
  logic         done;
  logic [n-1:0] salida;
  logic [n-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, control, A, B,
    input  busy, done, salida, remainder, div_by_zero
  );

  modport slave (
    input  start, control, A, B,
    output busy, done, salida, remainder, div_by_zero
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add, LSB first) and restoring divide (MSB first),
// one bit per cycle, sharing operand registers and the iteration counter.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_muldiv_seq_if.slave    bus
);

  localparam int                 CNT_W    = $clog2(n) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(n - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [n-1:0]     a_q, a_d;
  logic [n-1:0]     b_q, b_d;
  logic [n-1:0]     acc_q, acc_d;
  logic [n-1:0]     salida_q, salida_d;
  logic [n-1:0]     rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [n-1:0]     mul_sum;
  logic [n:0]       div_shift;
  logic [n:0]       div_diff;
  logic             div_ge;
  logic [n-1:0]     div_rem_nx;
  logic [n-1:0]     div_quo_nx;

  // Since the partial remainder stays below B, a trial difference that is
  // non-negative never reaches bit n, so bit n alone acts as the borrow.
  always_comb begin
    mul_sum    = acc_q + (b_q[0] ? a_q : '0);
    div_shift  = {acc_q, a_q[n-1]};
    div_diff   = div_shift - {1'b0, b_q};
    div_ge     = ~div_diff[n];
    div_rem_nx = div_ge ? div_diff[n-1:0] : div_shift[n-1:0];
    div_quo_nx = {a_q[n-2:0], div_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    salida_d = salida_q;
    rem_d    = rem_q;
    dz_d     = dz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.control == ALU_MUL || bus.control == ALU_DIV)) begin
          a_d     = bus.A;
          b_d     = bus.B;
          acc_d   = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = (bus.control == ALU_MUL) ? MUL : DIV;
        end
      end

      MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        if (cnt_q == CNT_LAST) begin
          salida_d = mul_sum;
          rem_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A zero divisor spends one cycle here so its done pulse lands one edge after start.
      DIV: begin
        if (b_q == '0) begin
          salida_d = '1;
          rem_d    = a_q;
          dz_d     = 1'b1;
          state_d  = DONE;
        end else begin
          acc_d = div_rem_nx;
          a_d   = div_quo_nx;
          if (cnt_q == CNT_LAST) begin
            salida_d = div_quo_nx;
            rem_d    = div_rem_nx;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      salida_q <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      salida_q <= salida_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.salida      = salida_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;

endmodule
